// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path: the receive FSM state
//   encoding and the frame geometry (oversampling ratio, data bits).
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   First-word fall-through FIFO for received bytes.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, wdata     write request and data; ignored when full
//     pop             read request; ignored when empty
//     rdata           head entry (0 when empty)
//     level           occupancy 0..DEPTH
//     full, empty     status flags
module uart_rx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = wptr - rptr;

  // Gate the head with empty so the stale/uninitialised array never leaks out.
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   UART 8N1 receiver with 16x oversampling and a receive FIFO.
//   Ports:
//     wb_clk_i, wb_rst_ni  clock, asynchronous active-low reset
//     uart_rx              raw pad input (asynchronous, idle high)
//     en                   receiver enable
//     prescale             oversample tick period minus one, in clocks
//     rx_data/rx_valid/rx_ready  head-of-FIFO byte stream
//     rx_level             FIFO occupancy
//     frame_err            1-cycle pulse on a bad stop bit
//     overrun              1-cycle pulse when a byte is dropped on a full FIFO
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PRESCALE_W = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic                          uart_rx,
  input  logic                          en,
  input  logic [PRESCALE_W-1:0]         prescale,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          overrun
);

  // Synchronizer plus one history flop for edge detection.
  logic sync1, rx_s, rx_prev, fall;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= uart_rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  rx_state_t              state, state_next;
  logic [3:0]             sc, sc_next;
  logic [2:0]             bc, bc_next;
  logic [DATA_BITS-1:0]   sr, sr_next;
  logic                   push, ferr_set;

  // Tick generator. The period is latched at every reload so a prescale
  // change never produces a truncated or stretched oversample period.
  logic [PRESCALE_W-1:0] cnt, presc_q;
  logic                  tick;

  assign tick = en && (state != IDLE) && (cnt == presc_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt     <= '0;
      presc_q <= '0;
    end else if (!en || state == IDLE || tick) begin
      cnt     <= '0;
      presc_q <= prescale;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= IDLE;
      sc    <= '0;
      bc    <= '0;
      sr    <= '0;
    end else begin
      state <= state_next;
      sc    <= sc_next;
      bc    <= bc_next;
      sr    <= sr_next;
    end
  end

  always_comb begin
    state_next = state;
    sc_next    = sc;
    bc_next    = bc;
    sr_next    = sr;
    push       = 1'b0;
    ferr_set   = 1'b0;
    if (!en) begin
      state_next = IDLE;
      sc_next    = '0;
      bc_next    = '0;
    end else begin
      case (state)
        IDLE: begin
          sc_next = '0;
          bc_next = '0;
          if (fall) state_next = START;
        end
        START: if (tick) begin
          // Mid-point of the start bit: a high line means it was a glitch.
          if (sc == 4'(OVERSAMPLE / 2 - 1)) begin
            state_next = rx_s ? IDLE : DATA;
            sc_next    = '0;
            bc_next    = '0;
          end else begin
            sc_next = sc + 4'd1;
          end
        end
        DATA: if (tick) begin
          if (sc == 4'(OVERSAMPLE - 1)) begin
            sc_next = '0;
            sr_next = {rx_s, sr[DATA_BITS-1:1]};
            if (bc == 3'(DATA_BITS - 1)) state_next = STOP;
            else                         bc_next    = bc + 3'd1;
          end else begin
            sc_next = sc + 4'd1;
          end
        end
        STOP: if (tick) begin
          if (sc == 4'(OVERSAMPLE - 1)) begin
            sc_next = '0;
            if (rx_s) begin
              push       = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_set   = 1'b1;
              state_next = WAIT_IDLE;
            end
          end else begin
            sc_next = sc + 4'd1;
          end
        end
        WAIT_IDLE: if (rx_s) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  logic fifo_full, fifo_empty;

  uart_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (push),
    .wdata (sr),
    .pop   (rx_ready),
    .rdata (rx_data),
    .level (rx_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;

  // Full is judged before any same-cycle pop, so a concurrent pop still drops.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= push & fifo_full;
    end
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive front-end of the UART macro: takes the raw `uart_rx` pad input, synchronizes it, and recovers 8N1 frames with 16x oversampling. Received bytes are buffered in a small FIFO and presented to the Wishbone register block as a valid/ready stream. It also produces framing-error and overrun pulses for the register block and its interrupt logic.

## Interface
- `FIFO_DEPTH`, 16: receive FIFO entries; power of two, ≥2.
- `PRESCALE_W`, 16: width of the oversample prescaler.

Ports, clock and reset first:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_ni` in 1: reset, asynchronous assert, active-low.
- `uart_rx` in 1: raw pad line; idle high; asynchronous to `wb_clk_i`.
- `en` in 1: receiver enable.
- `prescale` in PRESCALE_W: oversample tick period minus 1, in clocks.
- `rx_data` out 8: head-of-FIFO byte.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer pops the head when this and `rx_valid` are both high.
- `rx_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `frame_err` out 1: one-cycle pulse on a bad stop bit.
- `overrun` out 1: one-cycle pulse when a byte is dropped because the FIFO is full.

## Operation
- **Synchronizer:** 2-flop synchronizer on `uart_rx`, reset value 1. A third flop holds the previous sample for falling-edge detection.
- **Tick generator:**
  - Counter counts 0..`prescale`; `tick` asserts in the cycle the count equals `prescale`, then the counter reloads to 0.
  - `prescale`=0 gives a tick every cycle.
  - A changed `prescale` takes effect at the next reload.
  - The counter is held at 0 in IDLE, so phase is aligned to the start edge.
- **State machine** (bit-tick counter `sc` 0..15, bit counter `bc` 0..7, shift register `sr`):
  - IDLE: a falling edge of the synchronized line with `en`=1 goes to START; `sc`=0.
  - START: at `sc`=7, sample the line. If 1, it was a glitch: go to IDLE. If 0, go to DATA with `sc`=0, `bc`=0.
  - DATA: on every tick where `sc`=15, shift the sample into `sr` MSB, LSB-first reception. After `bc`=7, go to STOP.
  - STOP: at `sc`=15, sample the line.
    - If 1: push `sr` into the FIFO, then go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: remain until the synchronized line is 1, then go to IDLE. This covers break conditions.
- **Disable:** `en`=0 forces the FSM to IDLE and clears the counters in the next cycle. The FIFO contents and pop path are unaffected.
- **FIFO** (sub-module):
  - Read pointer and write pointer each carry an extra wrap bit. Full means the indices are equal and the wrap bits differ.
  - A push while full (as evaluated before any same-cycle pop) drops the byte and pulses `overrun`. This holds even if a pop occurs in the same cycle.
  - A pop while empty is ignored.
  - A simultaneous push and pop when not full changes the pointers but leaves `rx_level` unchanged.
  - `rx_data` is the head-of-FIFO byte (first-word fall-through) and is stable while `rx_valid`=1 and `rx_ready`=0.

## Timing
- **Reset values:**
  - outputs: `rx_data`=0x00, `rx_valid`=0, `rx_level`=0, `frame_err`=0, `overrun`=0
  - internal: FSM=IDLE, pointers=0, synchronizer=1
- **Sampling points:**
  - Pad-to-synchronized latency: 2 clocks.
  - Start is validated 8 ticks after the edge is detected (mid-bit).
  - Data bit n is sampled 8+16·(n+1) ticks after the edge.
  - The stop bit is sampled 152 ticks after the edge.
- **FIFO/status latency:**
  - Push to `rx_valid`/`rx_level` update: 1 clock.
  - Pop to the next head byte on `rx_data`: 1 clock.
- `frame_err`/`overrun` are asserted in the cycle after the stop sample, exactly 1 clock wide.
- **Reset mid-frame:** the partial frame is lost; after release the FSM waits for a fresh falling edge.

## Structure
- Shared package `uart_pkg`:
  - RX state enum `{IDLE, START, DATA, STOP, WAIT_IDLE}`
  - `OVERSAMPLE`=16
  - `DATA_BITS`=8
- Sub-module `uart_rx_fifo`: parameterized by width and depth; ports for push/pop, data, level, full and empty.
- The TX path and Wishbone register decode are outside this block.

## Test plan
- **Single byte:** `prescale`=0; drive 0xA5 (8N1, 16 clocks/bit); hold `rx_ready`=0.
  - Expect `rx_valid`=1 with `rx_data`=0xA5 and `rx_level`=1 one clock after the stop sample.
  - Expect no error pulses.
- **Start glitch:** a 4-clock low pulse on `uart_rx`.
  - Expect the FSM back in IDLE at the start-validation sample.
  - Expect no push and no `frame_err`.
- **Framing error:** send 0x3C with the stop bit held 0 for 40 clocks.
  - Expect one `frame_err` pulse, `rx_level` unchanged, and the FSM in WAIT_IDLE until the line rises.
  - A following byte 0x5A is received correctly.
- **Overrun:** with `rx_ready`=0, send 17 bytes 0x00..0x10.
  - Expect `rx_level`=16 and one `overrun` pulse on the 17th byte.
  - Pops return 0x00..0x0F in order.
- **Full with same-cycle pop:** FIFO full; assert `rx_ready` in the cycle the 17th byte's push occurs.
  - Expect `overrun` pulse, byte dropped, `rx_level`=15.
- **Prescale and reset:**
  - `prescale`=3 (64 clocks/bit): 0x81 is received.
  - Assert `wb_rst_ni` low mid-DATA: all outputs return to reset values immediately, and the next full frame 0x7E is received.
